q1_bus_target: RTL and testbench

//  Responder for the Q1 CPU memory bus: answers every rd/wr cycle issued by q1cpu.

---
 rtl/q1_bus_target.sv | 147 ++++++++++++++
 tb/tb_q1_bus_target.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/q1_bus_target.sv
// q1_bus_target: memory and I/O responder for the Q1 CPU bus.
// RAM is mirrored below 0xFF00; TX FIFO, status, RX holding register and timer sit at 0xFF00-0xFF03.
module q1_bus_target #(
  parameter int    RAM_BITS   = 12,
  parameter int    FIFO_DEPTH = 4,
  parameter int    PRESCALE   = 100,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] addr_in,
  inout  wire  [7:0]  data_io,
  input  logic        rd_in,
  input  logic        wr_in,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

  logic [7:0]       r_ram  [2**RAM_BITS];
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_tx_ovf;
  logic             r_rx_full;
  logic [7:0]       r_rx_data;
  logic [7:0]       r_timer;
  logic [PS_W-1:0]  r_presc;

  logic       w_io;
  logic       w_sel_tx;
  logic       w_sel_st;
  logic       w_sel_rx;
  logic       w_sel_tm;
  logic       w_acc_wr;
  logic       w_acc_rd;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_push_ok;
  logic       w_rx_cap;
  logic       w_rx_pop;
  logic [7:0] w_status;
  logic [7:0] w_rd_data;

  assign w_io     = (addr_in[15:8] == 8'hFF);
  assign w_sel_tx = w_io & (addr_in[7:0] == 8'h00);
  assign w_sel_st = w_io & (addr_in[7:0] == 8'h01);
  assign w_sel_rx = w_io & (addr_in[7:0] == 8'h02);
  assign w_sel_tm = w_io & (addr_in[7:0] == 8'h03);

  assign w_acc_wr = wr_in & ~rst_in;
  assign w_acc_rd = rd_in & ~wr_in;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = ~w_empty & tx_ready_in;
  assign w_push    = w_acc_wr & w_sel_tx;
  // A push into a full FIFO still lands if the head leaves in the same cycle
  assign w_push_ok = w_push & (~w_full | w_pop);

  assign w_rx_cap = rx_valid_in & rx_ready_out;
  assign w_rx_pop = w_acc_rd & ~rst_in & w_sel_rx;

  assign w_status = {4'b0000, r_tx_ovf, r_rx_full, w_empty, w_full};

  always_comb begin
    w_rd_data = 8'h00;
    if (!w_io) begin
      w_rd_data = r_ram[addr_in[RAM_BITS-1:0]];
    end else begin
      case (addr_in[7:0])
        8'h01:   w_rd_data = w_status;
        8'h02:   w_rd_data = r_rx_full ? r_rx_data : 8'h00;
        8'h03:   w_rd_data = r_timer;
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  assign data_io      = w_acc_rd ? w_rd_data : 8'hzz;
  assign tx_valid_out = ~w_empty;
  assign tx_data_out  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign rx_ready_out = ~r_rx_full & ~rst_in;

  always_ff @(posedge clk_in) begin
    if (wr_in && !w_io) r_ram[addr_in[RAM_BITS-1:0]] <= data_io;
  end

  always_ff @(posedge clk_in) begin
    if (w_push_ok && !rst_in) r_fifo[r_wr_ptr] <= data_io;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      if (w_acc_wr && w_sel_st) r_tx_ovf <= 1'b0;
      else if (w_push && !w_push_ok) r_tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rx_full <= 1'b0;
      r_rx_data <= 8'h00;
    end else if (w_rx_cap) begin
      r_rx_full <= 1'b1;
      r_rx_data <= rx_data_in;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_timer <= 8'h00;
      r_presc <= '0;
    end else if (w_acc_wr && w_sel_tm) begin
      r_timer <= data_io;
      r_presc <= '0;
    end else if (r_presc == PS_LAST) begin
      r_timer <= r_timer + 8'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

endmodule

// File: tb/tb_q1_bus_target.sv
// tb_q1_bus_target: directed and randomized bus traffic checked against a queue/array model.
module tb_q1_bus_target;
  localparam int RB = 12;
  localparam int FD = 4;
  localparam int PS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, wr, tx_ready, rx_valid;
  logic [15:0] addr;
  logic [7:0]  wdat, rx_data;
  wire  [7:0]  data_io;
  wire  [7:0]  tx_data;
  wire         tx_valid, rx_ready;

  assign data_io = wr ? wdat : 8'hzz;

  q1_bus_target #(.RAM_BITS(RB), .FIFO_DEPTH(FD), .PRESCALE(PS), .INIT_FILE("")) dut (
    .clk_in(clk), .rst_in(rst), .addr_in(addr), .data_io(data_io),
    .rd_in(rd), .wr_in(wr), .tx_data_out(tx_data), .tx_valid_out(tx_valid),
    .tx_ready_in(tx_ready), .rx_data_in(rx_data), .rx_valid_in(rx_valid),
    .rx_ready_out(rx_ready)
  );

  int tot = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_ram  [4096];
  bit         m_ramw [4096];
  logic [7:0] m_txq [$];
  bit         m_ovf = 1'b0, m_rxf = 1'b0;
  logic [7:0] m_rxd = 8'h00, m_timer = 8'h00;
  int         m_presc = 0;

  logic [7:0] o_rd, o_txd;
  logic       o_txv, o_rxr;

  task automatic chk(string n, int act, int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(logic [15:0] a);
    if (a < 16'hFF00) return m_ram[a[11:0]];
    case (a)
      16'hFF01: return {4'b0000, m_ovf, m_rxf, m_txq.size() == 0, m_txq.size() == FD};
      16'hFF02: return m_rxf ? m_rxd : 8'h00;
      16'hFF03: return m_timer;
      default:  return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit full, pop;
    if (wr && addr < 16'hFF00) begin
      m_ram[addr[11:0]]  = wdat;
      m_ramw[addr[11:0]] = 1'b1;
    end
    if (rst) begin
      m_txq.delete();
      m_ovf = 0; m_rxf = 0; m_rxd = 8'h00; m_timer = 8'h00; m_presc = 0;
      return;
    end
    full = (m_txq.size() == FD);
    pop  = (m_txq.size() != 0) && tx_ready;
    if (pop) void'(m_txq.pop_front());
    if (wr && addr == 16'hFF00) begin
      if (!full || pop) m_txq.push_back(wdat);
      else m_ovf = 1'b1;
    end
    if (wr && addr == 16'hFF01) m_ovf = 1'b0;
    if (rx_valid && !m_rxf) begin
      m_rxf = 1'b1;
      m_rxd = rx_data;
    end else if (rd && !wr && addr == 16'hFF02) begin
      m_rxf = 1'b0;
    end
    if (wr && addr == 16'hFF03) begin
      m_timer = wdat;
      m_presc = 0;
    end else begin
      m_presc++;
      if (m_presc == PS) begin
        m_presc = 0;
        m_timer = 8'(m_timer + 8'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_valid", int'(tx_valid), int'(m_txq.size() != 0));
      chk("tx_data", int'(tx_data), (m_txq.size() != 0) ? int'(m_txq[0]) : 0);
      chk("rx_ready", int'(rx_ready), int'(!m_rxf && !rst));
      if (rd && !wr && !rst && (addr >= 16'hFF00 || m_ramw[addr[11:0]]))
        chk("rd_data", int'(data_io), int'(exp_rd(addr)));
    end
  end

  task automatic cyc(bit r, bit w, logic [15:0] a, logic [7:0] d, bit txr, bit rxv,
                     logic [7:0] rxd, bit rs);
    rd = r; wr = w; addr = a; wdat = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd; rst = rs;
    @(negedge clk);
    o_rd = data_io; o_txd = tx_data; o_txv = tx_valid; o_rxr = rx_ready;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bwr(logic [15:0] a, logic [7:0] d, bit txr);
    cyc(1'b0, 1'b1, a, d, txr, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic brd(logic [15:0] a, bit txr);
    cyc(1'b1, 1'b0, a, 8'h00, txr, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(bit txr);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, txr, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; wdat = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      m_ram[i] = 8'h00;
      m_ramw[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    brd(16'hFF01, 1'b0);
    chk("reset_status", int'(o_rd), 8'h02);
    chk("reset_txv", int'(o_txv), 0);

    bwr(16'h0123, 8'h5A, 1'b0);
    brd(16'h0123, 1'b0);
    chk("ram_rd", int'(o_rd), 8'h5A);
    brd(16'h1123, 1'b0);
    chk("ram_mirror", int'(o_rd), 8'h5A);

    for (int i = 1; i <= 5; i++) bwr(16'hFF00, 8'(i), 1'b0);
    brd(16'hFF01, 1'b0);
    chk("status_full_ovf", int'(o_rd), 8'h09);
    bwr(16'hFF01, 8'h00, 1'b0);
    brd(16'hFF01, 1'b0);
    chk("status_ovf_clr", int'(o_rd), 8'h01);

    bwr(16'hFF00, 8'h77, 1'b1);
    chk("pushpop_head", int'(o_txd), 8'h01);
    brd(16'hFF01, 1'b0);
    chk("pushpop_status", int'(o_rd), 8'h01);
    drain_exp[0] = 8'h02; drain_exp[1] = 8'h03; drain_exp[2] = 8'h04; drain_exp[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("drain", int'(o_txd), int'(drain_exp[i]));
    end
    idle(1'b1);
    chk("drain_empty", int'(o_txv), 0);

    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0);
    idle(1'b0);
    chk("rx_ready_low", int'(o_rxr), 0);
    brd(16'hFF01, 1'b0);
    chk("status_rx", int'(o_rd), 8'h06);
    brd(16'hFF02, 1'b0);
    chk("rx_data", int'(o_rd), 8'hC3);
    idle(1'b0);
    chk("rx_ready_high", int'(o_rxr), 1);
    brd(16'hFF02, 1'b0);
    chk("rx_empty_rd", int'(o_rd), 8'h00);

    bwr(16'hFF03, 8'hFF, 1'b0);
    brd(16'hFF03, 1'b0);
    chk("timer_wr", int'(o_rd), 8'hFF);
    idle(1'b0);
    brd(16'hFF03, 1'b0);
    chk("timer_wrap", int'(o_rd), 8'h00);
    brd(16'hFF04, 1'b0);
    chk("unmapped_rd", int'(o_rd), 8'h00);
    brd(16'hFF00, 1'b0);
    chk("txdata_rd", int'(o_rd), 8'h00);

    bwr(16'hFF00, 8'h11, 1'b0);
    bwr(16'hFF00, 8'h22, 1'b0);
    bwr(16'hFF00, 8'h33, 1'b0);
    bwr(16'h0010, 8'hAA, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1'b0);
    chk("rst_txv", int'(o_txv), 0);
    chk("rst_txd", int'(o_txd), 0);
    brd(16'hFF01, 1'b0);
    chk("rst_status", int'(o_rd), 8'h02);
    brd(16'h0010, 1'b0);
    chk("rst_ram_kept", int'(o_rd), 8'hAA);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      int k, op;
      bit r, w, rs;
      k = int'($urandom_range(0, 9));
      if (k < 4)      a = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 14)) << 12);
      else if (k < 8) a = 16'hFF00 + 16'($urandom_range(0, 4));
      else            a = 16'hFF00 | 16'($urandom_range(0, 255));
      op = int'($urandom_range(0, 6));
      r  = (op == 1 || op == 2 || op == 6);
      w  = (op == 3 || op == 4 || op == 6);
      rs = ($urandom_range(0, 299) == 0);
      if (rs) begin
        r = 1'b0;
        w = 1'b0;
      end
      cyc(r, w, a, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
          8'($urandom), rs);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
